// File: rtl/tracker_pkg.sv
// Types and constants shared by tracker and tracker_sequencer.
package tracker_pkg;

  localparam int MAXVOLUME = 15;

  localparam logic [1:0] INSTR_SIN    = 2'd0;
  localparam logic [1:0] INSTR_SQUARE = 2'd1;
  localparam logic [1:0] INSTR_SAW    = 2'd2;
  localparam logic [1:0] INSTR_RAND   = 2'd3;

  typedef struct packed {
    logic [1:0] instrument;
    logic [3:0] volume;
  } note_tp;

  typedef struct packed {
    logic       rest;
    logic [1:0] instrument;
    logic [3:0] volume;
    logic [3:0] speed;
  } row_tp;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_PLAY     = 2'd2
  } seq_state_t;

  // A rest row keeps its instrument but is silent.
  function automatic note_tp row_to_note(input row_tp r);
    note_tp n;
    n.instrument = r.instrument;
    n.volume     = r.rest ? 4'd0 : r.volume;
    return n;
  endfunction

endpackage

// File: rtl/tracker_sequencer_if.sv
// Host write/control port plus the note/speed feed into tracker.
interface tracker_sequencer_if #(parameter int ROWS = 16);
  import tracker_pkg::*;

  localparam int AW = $clog2(ROWS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  row_tp         wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [AW-1:0] last_row;
  logic [7:0]    tempo;

  note_tp        note;
  logic [3:0]    speed;
  logic [AW-1:0] row;
  logic          playing;
  logic          row_strobe;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop, last_row, tempo,
    input  note, speed, row, playing, row_strobe, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop, last_row, tempo,
    output note, speed, row, playing, row_strobe, done
  );

endinterface

// File: rtl/tracker_sequencer_pattern_ram.sv
// ROWS x row_tp simple dual-port RAM; the read register only updates on rd_en,
// so it doubles as the "current row" register of the sequencer.
module pattern_ram
  import tracker_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  row_tp         wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output row_tp         rd_data
);

  row_tp mem [ROWS];

  // Pattern storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: old data wins when reading and writing the same row on one edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tracker_sequencer.sv
// Steps through a stored pattern at a programmable tempo and feeds tracker's
// note/speed inputs; host controls playback with start/stop pulses.
module tracker_sequencer
  import tracker_pkg::*;
#(
  parameter int ROWS = 16
) (
  input  logic                clk,
  input  logic                rst,
  tracker_sequencer_if.slave  bus
);

  localparam int            AW      = $clog2(ROWS);
  localparam logic [AW:0]   ROW_MAX = (AW+1)'(ROWS - 1);

  seq_state_t    state_r;
  logic [7:0]    cnt_r;
  logic [AW-1:0] row_r;
  logic [AW-1:0] last_r;
  logic          playing_r;
  logic          strobe_r;
  logic          done_r;
  logic          shown_r;

  logic [AW-1:0] last_clamp_s;
  logic          at_last_s;
  logic          finish_s;
  logic [AW-1:0] next_row_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_addr_s;
  row_tp         ram_q_s;
  note_tp        note_s;
  logic [3:0]    speed_s;

  pattern_ram #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (ram_q_s)
  );

  // Row sequencing: next address and the prefetch read strobe.
  always_comb begin
    last_clamp_s = '0;
    if ({1'b0, bus.last_row} > ROW_MAX) begin
      last_clamp_s = ROW_MAX[AW-1:0];
    end else begin
      last_clamp_s = bus.last_row;
    end

    at_last_s  = (row_r == last_r);
    finish_s   = at_last_s && !bus.loop;
    next_row_s = at_last_s ? '0 : row_r + AW'(1);

    rd_en_s   = 1'b0;
    rd_addr_s = '0;
    case (state_r)
      ST_PREFETCH: begin
        rd_en_s   = !bus.stop;
        rd_addr_s = '0;
      end
      ST_PLAY: begin
        rd_en_s   = !bus.stop && (cnt_r == 8'd0) && !finish_s;
        rd_addr_s = next_row_s;
      end
      default: begin
        rd_en_s   = 1'b0;
        rd_addr_s = '0;
      end
    endcase
  end

  // Playback FSM, duration counter and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      row_r     <= '0;
      last_r    <= '0;
      playing_r <= 1'b0;
      strobe_r  <= 1'b0;
      done_r    <= 1'b0;
      shown_r   <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            state_r <= ST_PREFETCH;
            last_r  <= last_clamp_s;
          end
        end
        ST_PREFETCH: begin
          if (bus.stop) begin
            state_r <= ST_IDLE;
          end else begin
            state_r   <= ST_PLAY;
            playing_r <= 1'b1;
            strobe_r  <= 1'b1;
            shown_r   <= 1'b1;
            row_r     <= '0;
            cnt_r     <= bus.tempo;
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state_r   <= ST_IDLE;
            playing_r <= 1'b0;
            cnt_r     <= 8'd0;
          end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else if (finish_s) begin
            state_r   <= ST_IDLE;
            playing_r <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            row_r    <= next_row_s;
            cnt_r    <= bus.tempo;
            strobe_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          playing_r <= 1'b0;
          cnt_r     <= 8'd0;
        end
      endcase
    end
  end

  // Note/speed come straight off the RAM read register; volume is muted outside PLAY.
  always_comb begin
    note_s  = '0;
    speed_s = 4'd0;
    if (shown_r) begin
      note_s  = row_to_note(ram_q_s);
      speed_s = ram_q_s.speed;
      if (!playing_r) begin
        note_s.volume = 4'd0;
      end else begin
        note_s.volume = row_to_note(ram_q_s).volume;
      end
    end else begin
      note_s  = '0;
      speed_s = 4'd0;
    end
  end

  assign bus.note       = note_s;
  assign bus.speed      = speed_s;
  assign bus.row        = row_r;
  assign bus.playing    = playing_r;
  assign bus.row_strobe = strobe_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed-vector bench for tracker_sequencer; each observation packs
// {row, playing, row_strobe, done, instrument, volume, speed}.
module tb_tracker_sequencer;
  import tracker_pkg::*;

  localparam int ROWS = 16;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  tracker_sequencer_if #(.ROWS(ROWS)) bus ();

  tracker_sequencer #(.ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] expv(input logic [3:0] r, input logic p, input logic s,
                                       input logic d, input logic [1:0] ins,
                                       input logic [3:0] vol, input logic [3:0] spd);
    return {r, p, s, d, ins, vol, spd};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.row, bus.playing, bus.row_strobe, bus.done,
            bus.note.instrument, bus.note.volume, bus.speed};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [3:0] a, input logic rest, input logic [1:0] ins,
                           input logic [3:0] vol, input logic [3:0] spd);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = '{rest: rest, instrument: ins, volume: vol, speed: spd};
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rst = 1'b0;
    #13;
    e = expv(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL reset: got %05h want %05h", obs(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL reset_idle: got %05h want %05h", obs(), e);
    end
  endtask

  task automatic test_basic();
    logic [16:0] e;
    for (int i = 0; i < 4; i++) begin
      write_row(4'(i), 1'b0, 2'(i), 4'd15, 4'd1);
    end
    bus.tempo = 8'd3;
    bus.last_row = 4'd3;
    bus.loop = 1'b0;
    pulse_start();
    e = expv(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL basic_prefetch: got %05h want %05h", obs(), e);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      e = expv(4'(i / 4), 1'b1, (i % 4) == 0, 1'b0, 2'(i / 4), 4'd15, 4'd1);
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL basic[%0d]: got %05h want %05h", i, obs(), e);
      end
    end
    step();
    e = expv(4'd3, 1'b0, 1'b0, 1'b1, INSTR_RAND, 4'd0, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL basic_done: got %05h want %05h", obs(), e);
    end
    step();
    e = expv(4'd3, 1'b0, 1'b0, 1'b0, INSTR_RAND, 4'd0, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL basic_after: got %05h want %05h", obs(), e);
    end
  endtask

  task automatic test_loop();
    logic [16:0] e;
    bus.tempo = 8'd0;
    bus.loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      step();
      e = expv(4'(i % 4), 1'b1, 1'b1, 1'b0, 2'(i % 4), 4'd15, 4'd1);
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL loop[%0d]: got %05h want %05h", i, obs(), e);
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    e = expv(4'd1, 1'b0, 1'b0, 1'b0, INSTR_SQUARE, 4'd0, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL loop_stop: got %05h want %05h", obs(), e);
    end
  endtask

  task automatic test_rest();
    logic [16:0] tbl [5];
    tbl[0] = expv(4'd0, 1'b1, 1'b1, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    tbl[1] = expv(4'd0, 1'b1, 1'b0, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    tbl[2] = expv(4'd1, 1'b1, 1'b1, 1'b0, INSTR_SAW, 4'd0, 4'd2);
    tbl[3] = expv(4'd1, 1'b1, 1'b0, 1'b0, INSTR_SAW, 4'd0, 4'd2);
    tbl[4] = expv(4'd1, 1'b0, 1'b0, 1'b1, INSTR_SAW, 4'd0, 4'd2);
    write_row(4'd1, 1'b1, INSTR_SAW, 4'd15, 4'd2);
    bus.tempo = 8'd1;
    bus.last_row = 4'd1;
    bus.loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++;
      if (obs() !== tbl[i]) begin
        errs++;
        $display("FAIL rest[%0d]: got %05h want %05h", i, obs(), tbl[i]);
      end
    end
  endtask

  task automatic test_stop_start();
    logic [16:0] e;
    write_row(4'd1, 1'b0, INSTR_SQUARE, 4'd15, 4'd1);
    bus.tempo = 8'd3;
    bus.last_row = 4'd3;
    bus.loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 2);
      step();
      bus.start = 1'b0;
      e = expv(4'(i / 4), 1'b1, (i % 4) == 0, 1'b0, 2'(i / 4), 4'd15, 4'd1);
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL stop_play[%0d]: got %05h want %05h", i, obs(), e);
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    e = expv(4'd2, 1'b0, 1'b0, 1'b0, INSTR_SAW, 4'd0, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL stop_mid: got %05h want %05h", obs(), e);
    end
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL start_stop_pair[%0d]: got %05h want %05h", i, obs(), e);
      end
    end
    pulse_start();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL stop_prefetch[%0d]: got %05h want %05h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [16:0] e;
    logic [16:0] z;
    z = expv(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    bus.tempo = 8'd3;
    bus.loop = 1'b1;
    pulse_start();
    step();
    step();
    e = expv(4'd0, 1'b1, 1'b0, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL areset_pre: got %05h want %05h", obs(), e);
    end
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (obs() !== z) begin
      errs++;
      $display("FAIL areset_now: got %05h want %05h", obs(), z);
    end
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (obs() !== z) begin
        errs++;
        $display("FAIL areset_idle[%0d]: got %05h want %05h", i, obs(), z);
      end
    end
    pulse_start();
    step();
    e = expv(4'd0, 1'b1, 1'b1, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    vecs++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL areset_restart: got %05h want %05h", obs(), e);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_live_write();
    logic [16:0] tbl [6];
    tbl[0] = expv(4'd0, 1'b1, 1'b1, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    tbl[1] = expv(4'd0, 1'b1, 1'b0, 1'b0, INSTR_SIN, 4'd15, 4'd1);
    tbl[2] = expv(4'd1, 1'b1, 1'b1, 1'b0, INSTR_SQUARE, 4'd15, 4'd1);
    tbl[3] = expv(4'd1, 1'b1, 1'b0, 1'b0, INSTR_SQUARE, 4'd15, 4'd1);
    tbl[4] = expv(4'd0, 1'b1, 1'b1, 1'b0, INSTR_SAW, 4'd7, 4'd3);
    tbl[5] = expv(4'd0, 1'b0, 1'b0, 1'b0, INSTR_SAW, 4'd0, 4'd3);
    bus.tempo = 8'd1;
    bus.last_row = 4'd1;
    bus.loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      bus.stop = (i == 5);
      step();
      bus.stop = 1'b0;
      bus.wr_en = 1'b0;
      if (i == 0) begin
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = '{rest: 1'b0, instrument: INSTR_SAW, volume: 4'd7, speed: 4'd3};
      end
      vecs++;
      if (obs() !== tbl[i]) begin
        errs++;
        $display("FAIL live_write[%0d]: got %05h want %05h", i, obs(), tbl[i]);
      end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.last_row = 4'd0;
    bus.tempo = 8'd0;
    test_reset();
    test_basic();
    test_loop();
    test_rest();
    test_stop_start();
    test_async_reset();
    test_live_write();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/tracker_sequencer.md
# tracker_sequencer

Pattern sequencer that sits directly upstream of `tracker`: it stores a programmable pattern of rows and steps through them at a programmable tempo. It drives the `note` and `speed` inputs of `tracker`, so a song plays without the host touching the note bus every row. The host loads rows through a write port and controls playback with start/stop pulses. Looping is optional.

## Interface
- `ROWS`, 16: pattern depth in rows; `AW = $clog2(ROWS)`.
- `clk` input 1: sole clock, all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: pattern write strobe.
- `wr_addr` input AW: row address to write.
- `wr_data` input `row_tp` (11 bits): `{rest, instrument[1:0], volume[3:0], speed[3:0]}`.
- `start` input 1: one-cycle pulse that begins playback at row 0.
- `stop` input 1: one-cycle pulse that aborts playback.
- `loop` input 1: when 1, wrap to row 0 after `last_row`; when 0, end playback there.
- `last_row` input AW: final row index; sampled on an accepted `start`.
- `tempo` input 8: row length is `tempo+1` clk cycles; sampled at each row load.
- `note` output `note_tp`: to `tracker.note`.
- `speed` output 4: to `tracker.speed`.
- `row` output AW: index of the row currently on `note`.
- `playing` output 1: high in PLAY.
- `row_strobe` output 1: one-cycle pulse in the first cycle a new row is on `note`.
- `done` output 1: one-cycle pulse when a non-looping pattern ends.

## Operation
- States:
  - IDLE → PREFETCH on `start` with `stop`=0.
  - PREFETCH → PLAY after 1 cycle.
  - PLAY → IDLE on `stop`, or at the end of `last_row` when `loop`=0.
- Pattern RAM:
  - Synchronous read, 1-cycle latency.
  - Writes commit on the clock edge and are accepted in any state.
  - A write to the row currently playing does not alter `note` until that row is loaded again.
  - The RAM is not reset; rows never written read as X, and the host must write rows `0..last_row` before `start`.
- Row load:
  - `note.instrument` ← row.instrument.
  - `note.volume` ← row.rest ? 0 : row.volume.
  - `speed` ← row.speed.
  - The duration counter is loaded with `tempo`.
- Duration counter:
  - 8-bit down-counter.
  - When it reaches 0, the next row loads on the following edge.
  - The next row address is presented to the RAM in the cycle the counter equals 0 (prefetch), so rows abut with no gap.
- Row advance:
  - `row+1`, except at `row==last_row`.
  - At `last_row` with `loop`=1: wrap to 0.
  - At `last_row` with `loop`=0: go to IDLE and pulse `done`.
- On leaving PLAY for any reason:
  - `note.volume` = 0, `playing` = 0.
  - `instrument`, `speed` and `row` hold their last values.
- Input priority and holds:
  - `start` and `stop` in the same cycle: `stop` wins.
  - `start` while in PLAY or PREFETCH is ignored.
  - `stop` in PREFETCH returns to IDLE and no row is shown.
  - `last_row` ≥ ROWS is clamped to ROWS-1.
  - `loop` is evaluated live at each `last_row` boundary.

## Timing
- Reset (asynchronous, immediate): state IDLE, `note` = 0 (instrument 0, volume 0), `speed`=0, `row`=0, `playing`=0, `row_strobe`=0, `done`=0, counter 0.
- Start sequence:
  - Edge E: `start` is sampled.
  - E+1: PREFETCH, RAM address is 0.
  - E+2: PLAY, `note` holds row 0, `row_strobe`=1, `playing`=1.
- Each row is on `note` for exactly `tempo+1` cycles, so `tempo`=0 gives a new row every cycle.
- Non-looping end: after the final cycle of `last_row`, the next edge sets `done`=1 for one cycle, `playing`=0 and volume 0.
- `stop` sampled at edge S: outputs go quiet at S+1.
- Reset released mid-pattern: the block resumes in IDLE and needs a fresh `start`.

## Structure
- Shared package `tracker_pkg` holds:
  - `note_tp` struct: `instrument[1:0]`, `volume[3:0]`.
  - `row_tp` struct.
  - Instrument constants: `INSTR_SIN`=0, `INSTR_SQUARE`=1, `INSTR_SAW`=2, `INSTR_RAND`=3.
  - `MAXVOLUME`=15, used by both `tracker` and this block.
- Sub-module `pattern_ram`: ROWS×11 simple dual-port RAM with synchronous write and synchronous read, no reset.
- The FSM, counter and output registers live in the top module.

## Test plan
- Basic playback:
  - Stimulus: rows 0–3 = SIN/SQUARE/SAW/RAND, all volume 15 and speed 1; `tempo`=3, `last_row`=3, `loop`=0; pulse `start`.
  - Response: each instrument is held for 4 cycles starting at E+2, `row_strobe` pulses every 4 cycles, `done` pulses at E+18, then volume is 0.
- Looping:
  - Stimulus: same pattern with `loop`=1, `tempo`=0.
  - Response: `row` sequence 0,1,2,3,0,1… with a strobe every cycle and no gap at the wrap.
- Rest row:
  - Stimulus: row 1 has rest=1, instrument SAW, volume 15.
  - Response: while `row`=1, `note.volume`=0 and `note.instrument`=SAW.
- Stop and start interactions:
  - Stimulus: `stop` mid-row 2; `start` and `stop` in the same cycle from IDLE; `start` during PLAY.
  - Response: IDLE one cycle after `stop`; the same-cycle pair stays in IDLE; the mid-play `start` does not change `row`.
- Asynchronous reset:
  - Stimulus: drop `rst` between clock edges during PLAY.
  - Response: all outputs are 0 immediately; after release, the block waits in IDLE until `start`.
- Live write:
  - Stimulus: write row 0 while row 0 is playing with `loop`=1.
  - Response: the new contents appear on the next pass through row 0, not the current one.
